// File: rtl/gated_edge_counter_if.sv
// Bus bundle for gated_edge_counter: pulse input, run/mode controls and measurement outputs.
// master drives controls and data_in; slave is the counter itself.
interface gated_edge_counter_if #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned LED_W = 4
);
    logic             en;
    logic [1:0]       mode;
    logic             data_in;
    logic             edge_pulse;
    logic [CNT_W-1:0] count_live;
    logic [CNT_W-1:0] result;
    logic             overflow;
    logic             result_valid;
    logic [LED_W-1:0] LED;
    logic             clk_out;

    modport master (
        output en, mode, data_in,
        input  edge_pulse, count_live, result, overflow, result_valid, LED, clk_out
    );

    modport slave (
        input  en, mode, data_in,
        output edge_pulse, count_live, result, overflow, result_valid, LED, clk_out
    );
endinterface

// File: rtl/gated_edge_counter.sv
// Gated edge counter: counts selected data_in edges over GATE_CYCLES-clock windows.
// Optional macro COUNT_SAT_EN makes the window count saturate instead of wrap.
module gated_edge_counter #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned GATE_CYCLES = 1000,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LED_W       = 4,
    parameter int unsigned DIV_HALF    = 1
) (
    input logic                  pll_inst1_CLKOUT0,
    input logic                  rst,
    gated_edge_counter_if.slave  bus
);
    localparam int unsigned GATE_W = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam int unsigned DIV_W  = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;

    typedef enum logic [1:0] {StIdle, StCount, StLatch} state_t;

    logic clk;
    assign clk = pll_inst1_CLKOUT0;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_q, prev_q, edge_pulse_q;
    logic                   rise, fall, edge_sel;

    state_t            state_q;
    logic [GATE_W-1:0] gate_q;
    logic [CNT_W-1:0]  count_q, result_q;
    logic              window_ovf_q, overflow_q, result_valid_q;

    logic [CNT_W:0]    sum_wide;
    logic [CNT_W-1:0]  sum;
    logic              carry;

    logic [DIV_W-1:0]  div_q;
    logic              clk_out_q;

    assign rise = s_q & ~prev_q;
    assign fall = ~s_q & prev_q;

    always_comb begin
        edge_sel = 1'b0;
        case (bus.mode)
            2'b00:   edge_sel = rise;
            2'b01:   edge_sel = fall;
            2'b10:   edge_sel = rise | fall;
            default: edge_sel = 1'b0;
        endcase
    end

    // Synchroniser output is re-registered so edge_pulse lands SYNC_STAGES+1 clocks after capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q       <= '0;
            s_q          <= 1'b0;
            prev_q       <= 1'b0;
            edge_pulse_q <= 1'b0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], bus.data_in};
            s_q          <= sync_q[SYNC_STAGES-1];
            prev_q       <= s_q;
            edge_pulse_q <= edge_sel;
        end
    end

    always_comb begin
        sum_wide = {1'b0, count_q} + {{CNT_W{1'b0}}, edge_pulse_q};
        carry    = sum_wide[CNT_W];
`ifdef COUNT_SAT_EN
        sum      = carry ? {CNT_W{1'b1}} : sum_wide[CNT_W-1:0];
`else
        sum      = sum_wide[CNT_W-1:0];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            gate_q         <= '0;
            count_q        <= '0;
            window_ovf_q   <= 1'b0;
            result_q       <= '0;
            overflow_q     <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            if (!bus.en) begin
                state_q      <= StIdle;
                gate_q       <= '0;
                count_q      <= '0;
                window_ovf_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: state_q <= StCount;
                    StCount: begin
                        gate_q  <= gate_q + GATE_W'(1);
                        count_q <= sum;
                        if (carry) window_ovf_q <= 1'b1;
                        if (gate_q == GATE_W'(GATE_CYCLES - 2)) state_q <= StLatch;
                    end
                    // Closing-cycle edge goes into this window's total, not the next one.
                    StLatch: begin
                        result_q       <= sum;
                        overflow_q     <= window_ovf_q | carry;
                        result_valid_q <= 1'b1;
                        gate_q         <= '0;
                        count_q        <= '0;
                        window_ovf_q   <= 1'b0;
                        state_q        <= StCount;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q     <= '0;
            clk_out_q <= 1'b0;
        end else if (div_q == DIV_W'(DIV_HALF - 1)) begin
            div_q     <= '0;
            clk_out_q <= ~clk_out_q;
        end else begin
            div_q     <= div_q + DIV_W'(1);
        end
    end

    assign bus.edge_pulse   = edge_pulse_q;
    assign bus.count_live   = count_q;
    assign bus.result       = result_q;
    assign bus.overflow     = overflow_q;
    assign bus.result_valid = result_valid_q;
    assign bus.LED          = ~result_q[LED_W-1:0];
    assign bus.clk_out      = clk_out_q;
endmodule

// File: tb/tb_gated_edge_counter.sv
// Self-checking bench for gated_edge_counter: scoreboard of expected window totals.
// Small config: CNT_W=4, GATE_CYCLES=20, DIV_HALF=3 so wrap, timing and divider are all visible.
module tb_gated_edge_counter;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned GC    = 20;
    localparam int unsigned SS    = 2;
    localparam int unsigned LED_W = 4;
    localparam int unsigned DH    = 3;

    typedef struct {
        int unsigned res;
        bit          ovf;
    } exp_t;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   pat   = 0;      // 0: data_in follows lvl, 1: period 4 (2H/2L), 2: toggle every clock
    logic lvl   = 1'b0;
    int   ph    = 0;
    int   ep_cnt = 0;
    exp_t sb_q[$];

    gated_edge_counter_if #(.CNT_W(CNT_W), .LED_W(LED_W)) bus ();

    gated_edge_counter #(
        .CNT_W      (CNT_W),
        .GATE_CYCLES(GC),
        .SYNC_STAGES(SS),
        .LED_W      (LED_W),
        .DIV_HALF   (DH)
    ) dut (
        .pll_inst1_CLKOUT0(clk),
        .rst              (rst),
        .bus              (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // data_in changes on the falling edge, well away from the sampling edge
    always @(negedge clk) begin
        case (pat)
            1: begin
                bus.data_in = (ph < 2);
                ph = (ph + 1) % 4;
            end
            2:       bus.data_in = ~bus.data_in;
            default: bus.data_in = lvl;
        endcase
        if (bus.edge_pulse) ep_cnt++;
    end

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rv(output int n);
        exp_t e;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.result_valid && n < 3 * GC);
        if (!bus.result_valid) begin
            check("rv_timeout", 0, 1);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end else if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("result", bus.result, e.res);
            check("overflow", bus.overflow, e.ovf);
            check("led", bus.LED, (~e.res) & ((1 << LED_W) - 1));
        end
    endtask

    task automatic push(input int unsigned r, input bit o);
        exp_t e;
        e.res = r;
        e.ovf = o;
        sb_q.push_back(e);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"}, bus.count_live, 0);
        check({tag, "_result"}, bus.result, 0);
        check({tag, "_ovf"}, bus.overflow, 0);
        check({tag, "_rv"}, bus.result_valid, 0);
        check({tag, "_ep"}, bus.edge_pulse, 0);
        check({tag, "_led"}, bus.LED, 4'hF);
        check({tag, "_clkout"}, bus.clk_out, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   e0;
        int   rv_seen;
        logic prev;
        int unsigned wrap_exp;

        rst = 1'b1;
        bus.en = 1'b0;
        bus.mode = 2'b00;
        bus.data_in = 1'b0;
        repeat (3) tick();
        check_reset_state("rst_init");
        rst = 1'b0;

        // Edge latency: SYNC_STAGES+1 clocks after the capturing edge, one cycle wide
        tick();
        lvl = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.edge_pulse && n < 12);
        check("ep_latency", n, SS + 2);
        tick();
        check("ep_width", bus.edge_pulse, 0);
        lvl = 1'b0;

        // Divider free-runs with en=0
        pat = 1;
        prev = bus.clk_out;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.clk_out == prev && n < 20);
        for (int k = 0; k < 2; k++) begin
            prev = bus.clk_out;
            n = 0;
            do begin
                tick();
                n++;
            end while (bus.clk_out == prev && n < 20);
            check("clk_out_half", n, DH);
        end

        // mode 00, period-4 data: 5 rising edges per window
        push(5, 0);
        bus.en = 1'b1;
        wait_rv(n);
        check("first_rv_delay", n, GC + 1);
        push(5, 0);
        push(5, 0);
        for (int k = 0; k < 2; k++) begin
            wait_rv(n);
            check("rv_period", n, GC);
        end

        // both edges
        bus.mode = 2'b10;
        wait_rv(n);
        push(10, 0);
        push(10, 0);
        repeat (2) wait_rv(n);

        // no edges counted, no strobes
        bus.mode = 2'b11;
        wait_rv(n);
        e0 = ep_cnt;
        push(0, 0);
        wait_rv(n);
        check("mode11_pulses", ep_cnt - e0, 0);

        // 20 edges into a 4-bit counter
`ifdef COUNT_SAT_EN
        wrap_exp = 15;
`else
        wrap_exp = 20 % 16;
`endif
        bus.mode = 2'b10;
        pat = 2;
        wait_rv(n);
        push(wrap_exp, 1);
        push(wrap_exp, 1);
        repeat (2) wait_rv(n);

        // back to a clean window, overflow clears
        bus.mode = 2'b00;
        pat = 1;
        wait_rv(n);
        push(5, 0);
        wait_rv(n);

        // en dropped mid-window: count cleared, result kept, no result_valid
        repeat (7) tick();
        bus.en = 1'b0;
        tick();
        check("drop_count", bus.count_live, 0);
        check("drop_result", bus.result, 5);
        rv_seen = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (bus.result_valid) rv_seen++;
        end
        check("idle_no_rv", rv_seen, 0);
        check("idle_led", bus.LED, 4'hA);
        push(5, 0);
        bus.en = 1'b1;
        wait_rv(n);
        check("reen_rv_delay", n, GC + 1);

        // Edge landing in the LATCH cycle belongs to the closing window
        pat = 0;
        lvl = 1'b0;
        wait_rv(n);
        push(0, 0);
        wait_rv(n);
        repeat (GC - 5) tick();
        lvl = 1'b1;
        push(1, 0);
        wait_rv(n);
        check("latch_edge_count_clear", bus.count_live, 0);

        // Asynchronous reset mid-run, then data_in high across release gives one rise
        repeat (5) tick();
        rst = 1'b1;
        #1;
        check_reset_state("rst_mid");
        repeat (2) tick();
        rst = 1'b0;
        push(1, 0);
        wait_rv(n);
        check("post_rst_rv_delay", n, GC + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gated_edge_counter.md
Name: gated_edge_counter

Overview:
- Parameterised successor to the board-test edge counter: counts selected edges of an asynchronous input over a fixed gate window, latches per-window totals, and drives an active-low LED bank plus a divided clock out.
- Used as a frequency/pulse-rate meter on the bring-up board, clocked from the PLL output.

Parameters:
CNT_W, 16, edge counter and result width (>=2)
GATE_CYCLES, 1000, window length in clocks (>=2)
SYNC_STAGES, 2, data_in synchroniser depth (>=2)
LED_W, 4, LED bank width (<=CNT_W)
DIV_HALF, 1, clk_out half-period in clocks (>=1)

Ports:
pll_inst1_CLKOUT0  in   1       system clock, all logic rising-edge
rst  in   1       asynchronous, active-high reset
en  in   1       run gate windows while high
mode  in   2       00 rising, 01 falling, 10 both, 11 none counted
data_in  in   1       asynchronous pulse input
edge_pulse  out  1       registered one-cycle strobe per selected edge
count_live  out  CNT_W   running count in current window
result  out  CNT_W   last latched window total
overflow  out  1       count exceeded 2^CNT_W-1 in last latched window
result_valid  out  1       one-cycle pulse when result/overflow update
LED  out  LED_W   active-low: ~result[LED_W-1:0]
clk_out  out  1       free-running divided clock

Behaviour:
- Reset is asynchronous and active-high (rst). While rst=1, all flops are 0: synchroniser, prev, edge_pulse, count_live, result, overflow, result_valid, gate counter, divider and clk_out. LED = all ones. FSM = IDLE.
- The synchroniser and prev reset to 0. A data_in held high across reset release therefore yields one rising edge. This is intended behaviour.
- Edge detect: s = synchroniser output; rise = s&~prev; fall = ~s&prev. The selected edge registers into edge_pulse.
- Latency: edge_pulse is high for exactly 1 cycle, SYNC_STAGES+1 clocks after the first clock edge that samples the new data_in level.
- mode is sampled every cycle. A change takes effect the next cycle and does not clear the count.
- FSM states:
  - IDLE: count_live=0, gate=0. en=1 -> COUNT next cycle.
  - COUNT: gate increments each cycle; count_live += edge_pulse. gate==GATE_CYCLES-2 -> LATCH.
  - LATCH (1 cycle): result <= count_live+edge_pulse (the closing edge is included); overflow <= window_ovf | carry; result_valid=1 next cycle; count_live, gate and window_ovf cleared -> COUNT.
- Period between result_valid pulses is exactly GATE_CYCLES clocks. No edge is lost or double-counted across the window boundary.
- en=0 in any state -> IDLE next cycle. count_live and gate are cleared; result, overflow and LED are retained; no result_valid.
- Arithmetic: count_live wraps modulo 2^CNT_W. Any carry out sets window_ovf (sticky until LATCH).
- Divider: counter 0..DIV_HALF-1; clk_out toggles on wrap. Independent of en/FSM. Period 2*DIV_HALF clocks.

Optional Feature:
COUNT_SAT_EN
- Defined: count_live (and the LATCH sum) saturates at 2^CNT_W-1 instead of wrapping; overflow is still set when an increment is attempted at saturation.
- Undefined: wrap-around as above.

Test Plan:
- Reset: assert rst mid-run -> all outputs 0 immediately, LED=4'hF, clk_out=0; deassert -> first result_valid GATE_CYCLES+1 clocks after en=1.
- GATE_CYCLES=20, mode=00, data_in period 4 clocks (2H/2L), en=1 -> result=5 every 20 clocks, LED=4'hA, overflow=0; edge_pulse 3 clocks after each sampled rise.
- Same stimulus, mode=10 -> result=10, LED=4'h5; mode=11 -> result=0, no edge_pulse.
- CNT_W=4, GATE_CYCLES=64, mode=10, data_in toggles every 2 clocks (32 edges) -> result=0, overflow=1; with COUNT_SAT_EN -> result=15, overflow=1.
- en dropped at gate=7 with count_live=3 -> count_live=0 next cycle, result unchanged, no result_valid; en re-raised -> full new window.
- DIV_HALF=3 -> clk_out period 6 clocks, toggling with en=0; edge placed in the LATCH cycle counted in the closing window (result +1), next window starts at 0.
